// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI pin and parallel-side signal bundle for spi_slave
//
// Purpose: groups the SPI pins and the tx/rx parallel handshake of spi_slave.
// Signals:
//   i_sck, i_ss, i_mosi        SPI pins from the master (asynchronous to clk)
//   o_miso, o_miso_en          slave-out data and its tri-state enable
//   i_tx_byte, i_tx_valid      next byte to transmit and its valid
//   o_tx_ready                 tx buffer empty
//   o_rx_byte, o_rx_valid      last received byte and its 1-cycle strobe
//   o_tx_underrun, o_abort     1-cycle status strobes
//   o_busy                     frame in progress
// Modports: slave (the responder), master (the driving side / bench).

interface spi_slave_if;
    logic       i_sck;
    logic       i_ss;
    logic       i_mosi;
    logic       o_miso;
    logic       o_miso_en;
    logic [7:0] i_tx_byte;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_byte;
    logic       o_rx_valid;
    logic       o_tx_underrun;
    logic       o_abort;
    logic       o_busy;

    modport slave (
        input  i_sck, i_ss, i_mosi, i_tx_byte, i_tx_valid,
        output o_miso, o_miso_en, o_tx_ready, o_rx_byte, o_rx_valid,
               o_tx_underrun, o_abort, o_busy
    );

    modport master (
        output i_sck, i_ss, i_mosi, i_tx_byte, i_tx_valid,
        input  o_miso, o_miso_en, o_tx_ready, o_rx_byte, o_rx_valid,
               o_tx_underrun, o_abort, o_busy
    );
endinterface

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 8-bit MSB-first responder with one-entry tx buffer
//
// Purpose: oversamples SCK/SS/MOSI in the clk domain, shifts received bits in on
// SCK rise and transmit bits out on SCK fall, back-to-back bytes within one SS frame.
// Ports:
//   clk      system clock, single domain
//   reset_n  asynchronous active-low reset
//   bus      spi_slave_if.slave: SPI pins, tx handshake, rx strobe, status strobes

module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    spi_slave_if.slave  bus
);

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t state, state_nx;

    logic [SYNC_STAGES-1:0] sck_sync, ss_sync, mosi_sync;
    logic       sck_d, ss_d;
    logic       sck_s, ss_s, mosi_s;
    logic       sck_rise, sck_fall, ss_fall, ss_rise;

    logic [7:0] tx_buf;
    logic       tx_full;
    logic [7:0] tx_shift;
    logic [6:0] rx_shift;
    logic [3:0] bit_cnt;
    logic [7:0] rx_byte_q;
    logic       rx_valid_q, underrun_q, abort_q;

    logic       load_evt, tx_write;

    // Input synchronizers plus one extra flop per edge-detected input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.i_sck};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.i_ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
            sck_d     <= sck_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign ss_s     = ss_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise =  sck_s & ~sck_d;
    assign sck_fall = ~sck_s &  sck_d;
    assign ss_fall  = ~ss_s  &  ss_d;
    assign ss_rise  =  ss_s  & ~ss_d;

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (ss_fall) state_nx = S_ACTIVE;
            S_ACTIVE: if (ss_rise) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.o_miso_en = 1'b0;
        bus.o_busy    = 1'b0;
        bus.o_miso    = 1'b0;
        if (state == S_ACTIVE) begin
            bus.o_miso_en = 1'b1;
            bus.o_busy    = 1'b1;
            bus.o_miso    = tx_shift[7];
        end
    end

    // A load happens at frame start and on the falling SCK edge closing a full byte.
    // SS rise wins over any same-cycle SCK edge, so it suppresses the boundary load.
    assign load_evt = ((state == S_IDLE) && ss_fall) ||
                      ((state == S_ACTIVE) && !ss_rise && sck_fall && (bit_cnt == 4'd8));
    assign tx_write = bus.i_tx_valid & ~tx_full;

    // TX buffer: a same-cycle write refills after the load has taken the old content
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_buf     <= 8'h00;
            tx_full    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= load_evt & ~tx_full;
            if (tx_write) tx_buf <= bus.i_tx_byte;
            if (load_evt)      tx_full <= tx_write;
            else if (tx_write) tx_full <= 1'b1;
        end
    end

    // Shift datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_shift   <= 8'h00;
            rx_shift   <= 7'h00;
            bit_cnt    <= 4'd0;
            rx_byte_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            abort_q    <= 1'b0;
            if (load_evt) begin
                tx_shift <= tx_full ? tx_buf : DEFAULT_TX;
                bit_cnt  <= 4'd0;
            end else if (state == S_ACTIVE) begin
                if (ss_rise) begin
                    abort_q <= (bit_cnt != 4'd0) && (bit_cnt != 4'd8);
                    bit_cnt <= 4'd0;
                end else if (sck_rise && (bit_cnt != 4'd8)) begin
                    rx_shift <= {rx_shift[5:0], mosi_s};
                    bit_cnt  <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        rx_byte_q  <= {rx_shift, mosi_s};
                        rx_valid_q <= 1'b1;
                    end
                end else if (sck_fall) begin
                    tx_shift <= {tx_shift[6:0], 1'b0};
                end
            end
        end
    end

    assign bus.o_tx_ready    = ~tx_full;
    assign bus.o_rx_byte     = rx_byte_q;
    assign bus.o_rx_valid    = rx_valid_q;
    assign bus.o_tx_underrun = underrun_q;
    assign bus.o_abort       = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave against a byte-level model

module tb_spi_slave;

    localparam int HALF = 25;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_slave_if bus ();

    spi_slave #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_fail = 0;

    // Byte-level model state
    logic [7:0] m_buf = 8'h00;
    bit         m_full = 1'b0;
    logic [7:0] m_last_rx = 8'h00;
    logic [7:0] exp_rx[$];
    logic [7:0] miso_log[$];
    int exp_underrun = 0, got_underrun = 0;
    int exp_abort = 0, got_abort = 0;
    bit prev_rx_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A load takes the buffer if full, otherwise the default byte with an underrun
    task automatic model_load(output logic [7:0] b);
        if (m_full) b = m_buf;
        else begin
            b = 8'hFF;
            exp_underrun++;
        end
        m_full = 1'b0;
    endtask

    task automatic tx_write(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready_before_write", 32'(bus.o_tx_ready), 32'(!m_full));
        if (!m_full) begin
            bus.i_tx_valid = 1'b1;
            bus.i_tx_byte  = b;
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
            m_buf  = b;
            m_full = 1'b1;
        end
    endtask

    // Compare process: every delivered rx byte must match the next one the master sent
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_rx_valid <= 1'b0;
        end else begin
            if (bus.o_rx_valid) begin
                check("rx_valid_one_cycle", 32'(prev_rx_valid), 32'd0);
                if (exp_rx.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got strobe with %0h, expected none at %0t",
                             bus.o_rx_byte, $time);
                end else begin
                    check("rx_byte", 32'(bus.o_rx_byte), 32'(exp_rx[0]));
                    m_last_rx = exp_rx.pop_front();
                end
            end
            if (bus.o_tx_underrun) got_underrun++;
            if (bus.o_abort)       got_abort++;
            prev_rx_valid <= bus.o_rx_valid;
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("rst_miso",      32'(bus.o_miso), 32'd0);
        check("rst_miso_en",   32'(bus.o_miso_en), 32'd0);
        check("rst_tx_ready",  32'(bus.o_tx_ready), 32'd1);
        check("rst_rx_byte",   32'(bus.o_rx_byte), 32'h00);
        check("rst_rx_valid",  32'(bus.o_rx_valid), 32'd0);
        check("rst_underrun",  32'(bus.o_tx_underrun), 32'd0);
        check("rst_abort",     32'(bus.o_abort), 32'd0);
        check("rst_busy",      32'(bus.o_busy), 32'd0);
        bus.i_ss = 1'b1;
        bus.i_sck = 1'b0;
        bus.i_mosi = 1'b0;
        bus.i_tx_valid = 1'b0;
        m_full = 1'b0;
        m_last_rx = 8'h00;
        exp_rx.delete();
        exp_underrun = 0;
        got_underrun = 0;
        exp_abort = 0;
        got_abort = 0;
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // One SS frame of nbits SCK cycles. refill writes a byte mid-way through every byte;
    // held expects i_tx_valid already high with a full buffer; reset_at aborts with reset.
    task automatic spi_frame(input int nbits, input bit refill, input logic [7:0] refill_first,
                             input logic [7:0] mosi_first, input bit held,
                             input logic [7:0] held_b, input int reset_at);
        logic [7:0] txb, mb, cap;
        bit first_refill;
        int guard;
        first_refill = 1'b1;
        mb = mosi_first;
        cap = 8'h00;
        @(negedge clk);
        bus.i_ss = 1'b0;
        model_load(txb);
        if (held) begin
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!bus.o_tx_ready && guard < 20);
            check("held_accept_timeout", 32'(guard < 20), 32'd1);
            @(negedge clk);
            bus.i_tx_valid = 1'b0;
            m_buf  = held_b;
            m_full = 1'b1;
            check("held_ready_low", 32'(bus.o_tx_ready), 32'd0);
        end
        for (int i = 0; i < nbits; i++) begin
            int bp;
            bp = i % 8;
            if (bp == 0) begin
                if (i != 0) mb = 8'($urandom);
                cap = 8'h00;
            end
            bus.i_mosi = mb[7-bp];
            repeat (HALF) @(negedge clk);
            bus.i_sck = 1'b1;
            check("miso_bit", 32'(bus.o_miso), 32'(txb[7-bp]));
            check("miso_en",  32'(bus.o_miso_en), 32'd1);
            check("busy",     32'(bus.o_busy), 32'd1);
            cap[7-bp] = bus.o_miso;
            if (bp == 7) begin
                exp_rx.push_back(mb);
                miso_log.push_back(cap);
            end
            if (i == reset_at) begin
                mid_reset();
                return;
            end
            repeat (10) @(negedge clk);
            if (bp == 3 && refill) begin
                tx_write(first_refill ? refill_first : 8'($urandom));
                first_refill = 1'b0;
            end
            repeat (HALF - 10) @(negedge clk);
            bus.i_sck = 1'b0;
            if (bp == 7) model_load(txb);
        end
        repeat (HALF) @(negedge clk);
        bus.i_ss = 1'b1;
        if (nbits % 8 != 0) exp_abort++;
        repeat (10) @(negedge clk);
        check("idle_miso",    32'(bus.o_miso), 32'd0);
        check("idle_miso_en", 32'(bus.o_miso_en), 32'd0);
        check("idle_busy",    32'(bus.o_busy), 32'd0);
        check("underrun_cnt", 32'(got_underrun), 32'(exp_underrun));
        check("abort_cnt",    32'(got_abort), 32'(exp_abort));
        check("rx_pending",   32'(exp_rx.size()), 32'd0);
        check("rx_hold",      32'(bus.o_rx_byte), 32'(m_last_rx));
        check("tx_ready",     32'(bus.o_tx_ready), 32'(!m_full));
    endtask

    initial begin
        bus.i_sck = 1'b0;
        bus.i_ss = 1'b1;
        bus.i_mosi = 1'b0;
        bus.i_tx_byte = 8'h00;
        bus.i_tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready", 32'(bus.o_tx_ready), 32'd1);
        check("reset_rx_byte",  32'(bus.o_rx_byte), 32'h00);
        check("reset_miso_en",  32'(bus.o_miso_en), 32'd0);
        check("reset_busy",     32'(bus.o_busy), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte: A5 out, 3C in
        tx_write(8'hA5);
        miso_log.delete();
        spi_frame(8, 1'b0, 8'h00, 8'h3C, 1'b0, 8'h00, -1);
        check("t1_miso_byte", 32'(miso_log[0]), 32'hA5);
        check("t1_rx_byte",   32'(bus.o_rx_byte), 32'h3C);
        check("t1_underrun",  32'(got_underrun), 32'd1);

        // Two bytes, buffer refilled with 5A during byte 1
        tx_write(8'hC3);
        miso_log.delete();
        spi_frame(16, 1'b1, 8'h5A, 8'h81, 1'b0, 8'h00, -1);
        check("t2_byte0", 32'(miso_log[0]), 32'hC3);
        check("t2_byte1", 32'(miso_log[1]), 32'h5A);

        // Empty buffer at frame start
        miso_log.delete();
        spi_frame(8, 1'b0, 8'h00, 8'h96, 1'b0, 8'h00, -1);
        check("t3_default", 32'(miso_log[0]), 32'hFF);
        check("t3_rx_byte", 32'(bus.o_rx_byte), 32'h96);

        // Partial frame then a clean frame
        spi_frame(3, 1'b0, 8'h00, 8'hE7, 1'b0, 8'h00, -1);
        check("t4_rx_unchanged", 32'(bus.o_rx_byte), 32'h96);
        spi_frame(8, 1'b0, 8'h00, 8'h42, 1'b0, 8'h00, -1);
        check("t4_rx_next", 32'(bus.o_rx_byte), 32'h42);

        // Reset in the middle of a byte, then a full frame
        tx_write(8'h77);
        spi_frame(16, 1'b1, 8'h99, 8'h10, 1'b0, 8'h00, 4);
        tx_write(8'h3E);
        miso_log.delete();
        spi_frame(8, 1'b0, 8'h00, 8'hD2, 1'b0, 8'h00, -1);
        check("t5_miso_byte", 32'(miso_log[0]), 32'h3E);
        check("t5_rx_byte",   32'(bus.o_rx_byte), 32'hD2);

        // Valid held while the buffer is full: accepted only after the next load
        tx_write(8'h11);
        @(negedge clk);
        bus.i_tx_byte  = 8'h22;
        bus.i_tx_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_not_ready", 32'(bus.o_tx_ready), 32'd0);
        miso_log.delete();
        spi_frame(16, 1'b0, 8'h00, 8'h5C, 1'b1, 8'h22, -1);
        check("t6_byte0", 32'(miso_log[0]), 32'h11);
        check("t6_byte1", 32'(miso_log[1]), 32'h22);

        // Randomized frames
        for (int f = 0; f < 25; f++) begin
            int nb;
            if ($urandom_range(0, 1) == 1 && !m_full) tx_write(8'($urandom));
            case ($urandom_range(0, 3))
                0:       nb = 8;
                1:       nb = 16;
                2:       nb = 24;
                default: nb = int'($urandom_range(1, 20));
            endcase
            spi_frame(nb, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                      1'b0, 8'h00, -1);
        end

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
